mips_ex_alu_unit: RTL and testbench
===================================

// Module: mips_ex_alu_unit
// PURPOSE
// - Execute-stage datapath core of the 5-stage MIPS pipeline: ALU control decode, 32-bit ALU with HI/LO registers, and branch-target adder.
// - Sits between the ID/EX register and the EX/MEM register.
// - Operands arrive already forwarded and ALUSrc-muxed.
// - Outputs the ALU result, zero flag and branch target.
// PARAMETERS
// - DATA_W  32  datapath width; only 32 is supported.
// PORTS
// - Clk            in   1   clock; HI/LO update on rising edge
// - Reset          in   1   asynchronous, active-low; clears HI/LO
// - ALUOp          in   5   operation class from the controller
// - Funct          in   6   instruction[5:0], used when ALUOp=0 or 9
// - Shamt          in   5   instruction[10:6]
// - A              in   32  operand A (rs value)
// - B              in   32  operand B (rt value or sign-extended immediate)
// - PCPlus4        in   32  PC+4 of the instruction
// - Offset         in   32  sign-extended immediate
// - Result         out  32  ALU result
// - Zero           out  1   1 when Result==0
// - BranchAddress  out 32  PCPlus4 + (Offset<<2)
// - HiLoWrite      out  1   decoded HI/LO write enable
// - Hi             out  32  HI register
// - Lo             out  32  LO register
// BEHAVIOUR
// - Result, Zero, BranchAddress and HiLoWrite are purely combinational: zero latency, no reset value.
// - Hi and Lo are the only state.
// - Reset low clears Hi and Lo to 0 immediately. Reset dominates Clk.
// - ALUOp decode:
//   - 0 = R-type (see Funct)
//   - 1 = add; 2 = sub; 3 = and; 4 = or, B zero-extended by caller; 5 = xor
//   - 6 = slt (signed); 7 = sltu (unsigned)
//   - 8 = lui: B[15:0]<<16
//   - 9 = SPECIAL2 (see Funct)
//   - 10..31 behave as add.
// - R-type Funct decode:
//   - 0x20/0x21 add; 0x22/0x23 sub; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor
//   - 0x2A slt; 0x2B sltu
//   - 0x00 sll B by Shamt; 0x02 srl B by Shamt; 0x03 sra B by Shamt
//   - 0x04 sllv B by A[4:0]; 0x06 srlv B by A[4:0]; 0x07 srav B by A[4:0]
//   - 0x10 mfhi -> Hi; 0x12 mflo -> Lo
//   - 0x11 mthi: Hi<=A; 0x13 mtlo: Lo<=A
//   - 0x18 mult (signed) {Hi,Lo}<=A*B; 0x19 multu (unsigned)
//   - 0x0A movz / 0x0B movn: Result=A
//   - Any other Funct -> Result 0.
// - SPECIAL2 Funct decode:
//   - 0x02 mul: Result = low 32 bits of signed A*B; Hi/Lo untouched
//   - 0x00 madd: {Hi,Lo} += signed A*B
//   - 0x04 msub: {Hi,Lo} -= signed A*B
//   - Any other Funct -> Result 0.
// - HiLoWrite=1 exactly for mthi, mtlo, mult, multu, madd, msub.
//   - Hi/Lo update on the rising Clk edge only when HiLoWrite=1.
//   - mthi leaves Lo unchanged; mtlo leaves Hi unchanged.
//   - Result during HI/LO writes is 0.
// - Arithmetic wraps modulo 2^32 (64 for madd/msub); no overflow traps or flags.
// - mfhi issued the cycle after mult returns the new value, since HI/LO are updated at the edge.
// - BranchAddress is independent of ALUOp; wraps modulo 2^32; uses a separate adder, not the ALU.
// - Zero reflects the final Result, including lui and mfhi.
// TESTING
// - Reset low mid-run with Hi=0x5 -> Hi=Lo=0 immediately. Edges while low keep them 0.
// - ALUOp=2, A=B=0x1234 -> Result=0, Zero=1. ALUOp=1, A=0xFFFFFFFF, B=1 -> Result=0, Zero=1 (wrap).
// - ALUOp=0, Funct=0x03, Shamt=4, B=0x80000000 -> 0xF8000000. Funct=0x02 -> 0x08000000.
// - ALUOp=0, Funct=0x2A, A=0xFFFFFFFF, B=1 -> 1; Funct=0x2B -> 0.
// - mult A=-2, B=3 then edge -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. Then madd A=B=2 -> Lo=0xFFFFFFFE. Then mfhi -> Result=0xFFFFFFFF.
// - PCPlus4=0x10, Offset=0xFFFFFFFF -> BranchAddress=0x0C. Offset=3 -> 0x1C.

Source files
------------

// File: rtl/mips_ex_alu_unit.sv
// -----------------------------------------------------------------------------
// mips_ex_alu_unit
//   Execute-stage datapath core of a 5-stage MIPS pipeline. It decodes the
//   ALU control and runs a 32-bit ALU with HI/LO registers. It also computes
//   the branch target on its own adder. Operands arrive already forwarded and
//   ALUSrc-muxed.
//
// Ports
//   Clk            in   1   clock; HI/LO update on rising edge
//   Reset          in   1   asynchronous, active-low; clears HI/LO
//   ALUOp          in   5   operation class from the controller
//   Funct          in   6   instruction[5:0] (used for R-type and SPECIAL2)
//   Shamt          in   5   instruction[10:6]
//   A              in   32  operand A (rs value)
//   B              in   32  operand B (rt value or sign-extended immediate)
//   PCPlus4        in   32  PC+4 of the instruction
//   Offset         in   32  sign-extended immediate
//   Result         out  32  ALU result (combinational)
//   Zero           out  1   1 when Result == 0
//   BranchAddress  out  32  PCPlus4 + (Offset << 2)
//   HiLoWrite      out  1   decoded HI/LO write enable
//   Hi             out  32  HI register
//   Lo             out  32  LO register
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mips_ex_alu_unit #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [4:0]        ALUOp,
  input  logic [5:0]        Funct,
  input  logic [4:0]        Shamt,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] PCPlus4,
  input  logic [DATA_W-1:0] Offset,
  output logic [DATA_W-1:0] Result,
  output logic              Zero,
  output logic [DATA_W-1:0] BranchAddress,
  output logic              HiLoWrite,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  // ALUOp classes
  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_LUI   = 5'd8;
  localparam logic [4:0] OP_SPEC2 = 5'd9;

  // R-type Funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MOVZ  = 6'h0A;
  localparam logic [5:0] F_MOVN  = 6'h0B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // SPECIAL2 Funct codes
  localparam logic [5:0] S2_MADD = 6'h00;
  localparam logic [5:0] S2_MUL  = 6'h02;
  localparam logic [5:0] S2_MSUB = 6'h04;

  localparam int W2 = 2 * DATA_W;

  logic [DATA_W-1:0] hi_q, lo_q, hi_d, lo_d;
  logic [DATA_W-1:0] result_d;
  logic              hilo_wr;

  logic [DATA_W-1:0] sum_ab, diff_ab;
  logic [DATA_W-1:0] slt_ab, sltu_ab;
  logic [W2-1:0]     a_sext, b_sext;
  logic [W2-1:0]     prod_s, prod_u;
  logic [W2-1:0]     hilo_cur;
  logic [4:0]        var_sh;

  assign sum_ab  = A + B;
  assign diff_ab = A - B;
  assign slt_ab  = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
  assign sltu_ab = {{(DATA_W-1){1'b0}}, (A < B)};

  // Both products are formed at full 64-bit width; the signed one uses
  // sign-extended operands so the low 64 bits are the exact signed product.
  assign a_sext   = {{DATA_W{A[DATA_W-1]}}, A};
  assign b_sext   = {{DATA_W{B[DATA_W-1]}}, B};
  assign prod_s   = a_sext * b_sext;
  assign prod_u   = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
  assign hilo_cur = {hi_q, lo_q};
  assign var_sh   = A[4:0];

  always_comb begin
    result_d = '0;
    hilo_wr  = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (ALUOp)
      OP_RTYPE: begin
        case (Funct)
          F_ADD, F_ADDU: result_d = sum_ab;
          F_SUB, F_SUBU: result_d = diff_ab;
          F_AND:         result_d = A & B;
          F_OR:          result_d = A | B;
          F_XOR:         result_d = A ^ B;
          F_NOR:         result_d = ~(A | B);
          F_SLT:         result_d = slt_ab;
          F_SLTU:        result_d = sltu_ab;
          F_SLL:         result_d = B << Shamt;
          F_SRL:         result_d = B >> Shamt;
          F_SRA:         result_d = $signed(B) >>> Shamt;
          F_SLLV:        result_d = B << var_sh;
          F_SRLV:        result_d = B >> var_sh;
          F_SRAV:        result_d = $signed(B) >>> var_sh;
          F_MFHI:        result_d = hi_q;
          F_MFLO:        result_d = lo_q;
          // The move condition is evaluated elsewhere; here we only pass A.
          F_MOVZ, F_MOVN: result_d = A;
          F_MTHI: begin
            hilo_wr = 1'b1;
            hi_d    = A;
          end
          F_MTLO: begin
            hilo_wr = 1'b1;
            lo_d    = A;
          end
          F_MULT: begin
            hilo_wr      = 1'b1;
            {hi_d, lo_d} = prod_s;
          end
          F_MULTU: begin
            hilo_wr      = 1'b1;
            {hi_d, lo_d} = prod_u;
          end
          default:       result_d = '0;
        endcase
      end
      OP_SUB:  result_d = diff_ab;
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_XOR:  result_d = A ^ B;
      OP_SLT:  result_d = slt_ab;
      OP_SLTU: result_d = sltu_ab;
      OP_LUI:  result_d = {B[15:0], 16'h0000};
      OP_SPEC2: begin
        case (Funct)
          S2_MUL: result_d = prod_s[DATA_W-1:0];
          S2_MADD: begin
            hilo_wr      = 1'b1;
            {hi_d, lo_d} = hilo_cur + prod_s;
          end
          S2_MSUB: begin
            hilo_wr      = 1'b1;
            {hi_d, lo_d} = hilo_cur - prod_s;
          end
          default: result_d = '0;
        endcase
      end
      // OP_ADD and every unassigned class (10..31) add.
      default: result_d = sum_ab;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_wr) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Branch target has its own adder so it never depends on ALUOp.
  assign BranchAddress = PCPlus4 + {Offset[DATA_W-3:0], 2'b00};

  assign Result    = result_d;
  assign Zero      = (result_d == '0);
  assign HiLoWrite = hilo_wr;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_mips_ex_alu_unit.sv
`timescale 1ns/1ps

module tb_mips_ex_alu_unit;

  logic        clk_sys;
  logic        rst_n;
  logic [4:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op_a, op_b, pc_plus4, offset;
  logic [31:0] result, branch_addr, hi, lo;
  logic        zero, hilo_write;

  int n_vec = 0;
  int n_err = 0;

  mips_ex_alu_unit #(.DATA_W(32)) dut (
    .Clk           (clk_sys),
    .Reset         (rst_n),
    .ALUOp         (alu_op),
    .Funct         (funct),
    .Shamt         (shamt),
    .A             (op_a),
    .B             (op_b),
    .PCPlus4       (pc_plus4),
    .Offset        (offset),
    .Result        (result),
    .Zero          (zero),
    .BranchAddress (branch_addr),
    .HiLoWrite     (hilo_write),
    .Hi            (hi),
    .Lo            (lo)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    funct  = fn;
    shamt  = sh;
    op_a   = a;
    op_b   = b;
  endtask

  // Apply a combinational vector and check Result, Zero and HiLoWrite=0.
  task automatic comb_vec(input string tag, input logic [4:0] op, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    drive(op, fn, sh, a, b);
    #1;
    check_eq({tag, ".res"}, result, exp);
    check_eq({tag, ".zero"}, {31'b0, zero}, {31'b0, (exp == 32'h0)});
    check_eq({tag, ".hlw"}, {31'b0, hilo_write}, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    pc_plus4 = 32'h0;
    offset   = 32'h0;
    drive(5'd0, 6'h00, 5'd0, 32'h0, 32'h0);
    #2;
    check_eq("rst.hi", hi, 32'h0);
    check_eq("rst.lo", lo, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Combinational ALU vectors
    comb_vec("sub_eq",   5'd2,  6'h00, 5'd0, 32'h00001234, 32'h00001234, 32'h00000000);
    comb_vec("add_wrap", 5'd1,  6'h00, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    comb_vec("sra",      5'd0,  6'h03, 5'd4, 32'h0,        32'h80000000, 32'hF8000000);
    comb_vec("srl",      5'd0,  6'h02, 5'd4, 32'h0,        32'h80000000, 32'h08000000);
    comb_vec("sll",      5'd0,  6'h00, 5'd8, 32'h0,        32'h000000AB, 32'h0000AB00);
    comb_vec("slt",      5'd0,  6'h2A, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
    comb_vec("sltu",     5'd0,  6'h2B, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    comb_vec("and_i",    5'd3,  6'h00, 5'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
    comb_vec("or_i",     5'd4,  6'h00, 5'd0, 32'h0000FF00, 32'h000000FF, 32'h0000FFFF);
    comb_vec("xor_i",    5'd5,  6'h00, 5'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
    comb_vec("slt_i",    5'd6,  6'h00, 5'd0, 32'h00000005, 32'hFFFFFFFF, 32'h00000000);
    comb_vec("sltu_i",   5'd7,  6'h00, 5'd0, 32'h00000005, 32'hFFFFFFFF, 32'h00000001);
    comb_vec("nor",      5'd0,  6'h27, 5'd0, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000);
    comb_vec("lui",      5'd8,  6'h00, 5'd0, 32'h0,        32'hABCD1234, 32'h12340000);
    comb_vec("srav",     5'd0,  6'h07, 5'd0, 32'h00000024, 32'h80000000, 32'hF8000000);
    comb_vec("sllv",     5'd0,  6'h04, 5'd0, 32'h00000008, 32'h00000001, 32'h00000100);
    comb_vec("movz",     5'd0,  6'h0A, 5'd0, 32'h0000DEAD, 32'h00000000, 32'h0000DEAD);
    comb_vec("rt_bad",   5'd0,  6'h3F, 5'd0, 32'h00000011, 32'h00000022, 32'h00000000);
    comb_vec("subu",     5'd0,  6'h23, 5'd0, 32'h00000001, 32'h00000002, 32'hFFFFFFFF);
    comb_vec("addu",     5'd0,  6'h21, 5'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
    comb_vec("op20_add", 5'd20, 6'h00, 5'd0, 32'h00000002, 32'h00000003, 32'h00000005);
    comb_vec("mul",      5'd9,  6'h02, 5'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1);
    comb_vec("s2_bad",   5'd9,  6'h01, 5'd0, 32'h00000003, 32'h00000005, 32'h00000000);

    // HI/LO sequence
    drive(5'd0, 6'h18, 5'd0, 32'hFFFFFFFE, 32'h00000003);  // mult -2*3
    #1;
    check_eq("mult.hlw", {31'b0, hilo_write}, 32'h1);
    check_eq("mult.res", result, 32'h0);
    check_eq("mult.pre_hi", hi, 32'h0);
    tick();
    check_eq("mult.hi", hi, 32'hFFFFFFFF);
    check_eq("mult.lo", lo, 32'hFFFFFFFA);

    drive(5'd9, 6'h00, 5'd0, 32'h00000002, 32'h00000002);  // madd 2*2
    tick();
    check_eq("madd.hi", hi, 32'hFFFFFFFF);
    check_eq("madd.lo", lo, 32'hFFFFFFFE);

    comb_vec("mfhi", 5'd0, 6'h10, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF);
    tick();
    check_eq("mfhi.keep", hi, 32'hFFFFFFFF);
    comb_vec("mflo", 5'd0, 6'h12, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFE);

    drive(5'd9, 6'h04, 5'd0, 32'h00000001, 32'hFFFFFFFE);  // msub 1*-2
    tick();
    check_eq("msub.hi", hi, 32'h0);
    check_eq("msub.lo", lo, 32'h0);
    comb_vec("mfhi0", 5'd0, 6'h10, 5'd0, 32'h0, 32'h0, 32'h00000000);

    drive(5'd0, 6'h19, 5'd0, 32'hFFFFFFFF, 32'h00000002);  // multu
    tick();
    check_eq("multu.hi", hi, 32'h00000001);
    check_eq("multu.lo", lo, 32'hFFFFFFFE);

    drive(5'd0, 6'h13, 5'd0, 32'h00000007, 32'h0);          // mtlo
    tick();
    check_eq("mtlo.hi", hi, 32'h00000001);
    check_eq("mtlo.lo", lo, 32'h00000007);

    drive(5'd0, 6'h11, 5'd0, 32'h00000005, 32'h0);          // mthi
    #1;
    check_eq("mthi.res", result, 32'h0);
    tick();
    check_eq("mthi.hi", hi, 32'h00000005);
    check_eq("mthi.lo", lo, 32'h00000007);

    drive(5'd9, 6'h02, 5'd0, 32'hFFFFFFFD, 32'h00000005);  // mul keeps HI/LO
    tick();
    check_eq("mul.hi", hi, 32'h00000005);
    check_eq("mul.lo", lo, 32'h00000007);

    // Mid-run async reset, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.hi", hi, 32'h0);
    check_eq("arst.lo", lo, 32'h0);
    drive(5'd0, 6'h11, 5'd0, 32'h00000009, 32'h0);          // mthi held during reset
    tick();
    tick();
    check_eq("rst_hold.hi", hi, 32'h0);
    check_eq("rst_hold.lo", lo, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst.hi", hi, 32'h00000009);

    // Branch target adder
    drive(5'd2, 6'h00, 5'd0, 32'h1, 32'h1);
    pc_plus4 = 32'h00000010;
    offset   = 32'hFFFFFFFF;
    #1;
    check_eq("br_neg", branch_addr, 32'h0000000C);
    offset = 32'h00000003;
    #1;
    check_eq("br_pos", branch_addr, 32'h0000001C);
    drive(5'd8, 6'h00, 5'd0, 32'h0, 32'hFFFFFFFF);
    #1;
    check_eq("br_indep", branch_addr, 32'h0000001C);
    pc_plus4 = 32'hFFFFFFFC;
    offset   = 32'h00000001;
    #1;
    check_eq("br_wrap", branch_addr, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
